// File: rtl/ext_ram_pkg.sv
// Shared types and timing helpers for the external byte-wide SRAM controller.
// Each 16-bit word is moved as two byte accesses of SETUP, STROBE and HOLD.
package ext_ram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam int WCNT_W = 4;
    localparam int unsigned WS_MAX = 15;

    // One byte costs SETUP + (WAIT_STATES+1) STROBE + HOLD cycles
    function automatic int unsigned byte_cycles(input int unsigned ws);
        return ws + 3;
    endfunction

endpackage

// File: rtl/ext_ram_wait_cnt.sv
// Strobe-width counter: loaded before STROBE, counts down to a terminal flag.
module ext_ram_wait_cnt
    import ext_ram_pkg::*;
#(
    parameter int W = WCNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         term
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign term = (cnt == '0);

endmodule

// File: rtl/ext_ram_ctrl.sv
// 16-bit word port onto an 8-bit asynchronous SRAM, low byte first.
// Every pad-facing signal and the handshake outputs come straight from flops.
module ext_ram_ctrl
    import ext_ram_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic              ram_cs_b,
    output logic              ram_oe_b,
    output logic              ram_we_b,
    output logic [ADDR_W:0]   ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_doe,
    input  logic [7:0]        ram_din
);

    localparam int unsigned STROBE_CYC = byte_cycles(WAIT_STATES) - 2;
    localparam logic [WCNT_W-1:0] LOAD_VAL = WCNT_W'(STROBE_CYC - 1);

    state_t            state;
    logic              hi;
    logic              rnw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        rd_lo;
    logic [7:0]        rd_hi;
    logic              term;

    ext_ram_wait_cnt #(
        .W(WCNT_W)
    ) u_wait_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (state == S_SETUP),
        .dec     (state == S_STROBE),
        .load_val(LOAD_VAL),
        .term    (term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            hi       <= 1'b0;
            rnw_q    <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_lo    <= '0;
            rd_hi    <= '0;
            rdata    <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            ram_cs_b <= 1'b1;
            ram_oe_b <= 1'b1;
            ram_we_b <= 1'b1;
            ram_addr <= '0;
            ram_dout <= '0;
            ram_doe  <= 1'b0;
        end else begin
            ack <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        rnw_q    <= rnw;
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        hi       <= 1'b0;
                        busy     <= 1'b1;
                        ram_cs_b <= 1'b0;
                        ram_addr <= {addr, 1'b0};
                        ram_dout <= wdata[7:0];
                        ram_doe  <= ~rnw;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    ram_oe_b <= ~rnw_q;
                    ram_we_b <= rnw_q;
                    state    <= S_STROBE;
                end
                S_STROBE: begin
                    if (term) begin
                        ram_oe_b <= 1'b1;
                        ram_we_b <= 1'b1;
                        if (rnw_q && hi) begin
                            rd_hi <= ram_din;
                        end else if (rnw_q) begin
                            rd_lo <= ram_din;
                        end
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!hi) begin
                        hi       <= 1'b1;
                        ram_addr <= {addr_q, 1'b1};
                        ram_dout <= wdata_q[15:8];
                        state    <= S_SETUP;
                    end else begin
                        ack      <= 1'b1;
                        ram_cs_b <= 1'b1;
                        ram_doe  <= 1'b0;
                        if (rnw_q) begin
                            rdata <= {rd_hi, rd_lo};
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
